// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcode, ALU control and FSM state definitions for ALU initiators.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_cmd_sequencer_pkg;

    // Command opcodes as presented on cmd_op
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // ALU control pins: bit1 = opp (add/sub path), bit0 = asn (subtract)
    localparam logic [1:0] CTRL_MUL = 2'b00;
    localparam logic [1:0] CTRL_ADD = 2'b10;
    localparam logic [1:0] CTRL_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU pin bundle between an ALU initiator and its environment.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface alu_cmd_sequencer_if #(
    parameter int PART_LEN = 8,
    parameter int CNT_W    = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [2*PART_LEN-1:0]   cmd_a;
    logic [2*PART_LEN-1:0]   cmd_b;
    logic [2*PART_LEN-1:0]   alu_a;
    logic [2*PART_LEN-1:0]   alu_b;
    logic [1:0]              alu_ctrl;
    logic [2*PART_LEN-1:0]   alu_res;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [2*PART_LEN-1:0]   rsp_data;
    logic                    rsp_err;
    logic [CNT_W-1:0]        done_cnt;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_res, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_err, done_cnt
    );

    // Command producer / response consumer / ALU side
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_res, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_err, done_cnt
    );

endinterface

// File: rtl/alu_op_decode.sv
// Maps a command opcode onto ALU control pins plus an illegal-opcode flag.
// Latency: combinational.
// Backpressure: none.
module alu_op_decode
    import alu_cmd_sequencer_pkg::*;
(
    input  logic [1:0] op,
    output logic [1:0] ctrl,
    output logic       err
);

    // Illegal opcodes fall back to ADD so they still run with normal timing
    always_comb begin
        ctrl = CTRL_ADD;
        err  = 1'b0;
        case (op)
            OP_MUL:  ctrl = CTRL_MUL;
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            default: begin
                ctrl = CTRL_ADD;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command front end for the registered add/sub/multiply ALU.
// Latency: response valid ALU_LAT+2 cycles after the accept cycle; one op per ALU_LAT+3 cycles.
// Backpressure: cmd_ready low while busy; response held stable until rsp_ready.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int PART_LEN = 8,
    parameter int ALU_LAT  = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    alu_cmd_sequencer_if.slave bus
);

    localparam int         W        = 2 * PART_LEN;
    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             capture;
    logic             rsp_done;

    logic [1:0]       dec_ctrl;
    logic             dec_err;

    logic             cmd_ready_q;
    logic [W-1:0]     alu_a_q;
    logic [W-1:0]     alu_b_q;
    logic [1:0]       alu_ctrl_q;
    logic             err_q;
    logic [3:0]       lat_cnt;
    logic [W-1:0]     rsp_data_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] done_cnt_q;

    alu_op_decode u_decode (
        .op   (bus.cmd_op),
        .ctrl (dec_ctrl),
        .err  (dec_err)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand/control pins, latency counter, result capture and completion count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_ready_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= CTRL_ADD;
            err_q       <= 1'b0;
            lat_cnt     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            // Registered ready: low in the first cycle out of reset, high whenever idle
            cmd_ready_q <= (state_nxt == ST_IDLE);
            // ALU pins change only on accept, so they hold through capture and beyond
            if (accept) begin
                alu_a_q    <= bus.cmd_a;
                alu_b_q    <= bus.cmd_b;
                alu_ctrl_q <= dec_ctrl;
                err_q      <= dec_err;
            end
            if (state == ST_ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == ST_WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (capture) begin
                rsp_data_q <= bus.alu_res;
                rsp_err_q  <= err_q;
            end
            // Wraps silently at all-ones
            if (rsp_done) begin
                done_cnt_q <= done_cnt_q + 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: ALU_LAT=1 instance (16-bit counter) and ALU_LAT=4 instance (2-bit counter).
// Latency: each instance drives a behavioural registered ALU of matching depth.
// Backpressure: rsp_ready held low for a stretch to check response stability.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.PART_LEN(8), .CNT_W(16)) b1 ();
    alu_cmd_sequencer_if #(.PART_LEN(8), .CNT_W(2))  b4 ();

    alu_cmd_sequencer #(.PART_LEN(8), .ALU_LAT(1), .CNT_W(16)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b1.slave)
    );

    alu_cmd_sequencer #(.PART_LEN(8), .ALU_LAT(4), .CNT_W(2)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b4.slave)
    );

    // Behavioural registered ALU
    function automatic logic [15:0] alu_f(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] m;
        m = {16'h0, a} * {16'h0, b};
        case (c)
            2'b11:   return a - b;
            2'b00:   return m[15:0];
            default: return a + b;
        endcase
    endfunction

    logic [15:0] p1;
    logic [15:0] p4 [4];

    // ALU result pipelines: depth 1 for dut1, depth 4 for dut4
    always @(posedge clk) begin
        p1    <= alu_f(b1.alu_ctrl, b1.alu_a, b1.alu_b);
        p4[0] <= alu_f(b4.alu_ctrl, b4.alu_a, b4.alu_b);
        for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
    end

    assign b1.alu_res = p1;
    assign b4.alu_res = p4[3];

    // Operation table for the ALU_LAT=4 instance
    logic [1:0]  t_op   [5] = '{OP_ADD,   OP_SUB,   OP_MUL,   OP_MUL,   OP_ADD};
    logic [15:0] t_a    [5] = '{16'h00FF, 16'h0000, 16'h0012, 16'h00FF, 16'h8000};
    logic [15:0] t_b    [5] = '{16'h0001, 16'h0001, 16'h0034, 16'h00FF, 16'h8000};
    logic [1:0]  t_ctrl [5] = '{CTRL_ADD, CTRL_SUB, CTRL_MUL, CTRL_MUL, CTRL_ADD};
    logic [15:0] t_exp  [5] = '{16'h0100, 16'hFFFF, 16'h03A8, 16'hFE01, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command on the selected instance from a negedge where it is idle; returns at the
    // negedge after the response handshake (rsp_ready must already be high)
    task automatic run_op(input bit s4, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] exp_ctrl, input logic [15:0] exp_dat, input logic exp_err,
                          input int exp_lat, input int exp_cnt, input string tag);
        int n;
        chk({tag, "/ready"}, 32'(s4 ? b4.cmd_ready : b1.cmd_ready), 32'd1);
        b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b;
        b4.cmd_op = op; b4.cmd_a = a; b4.cmd_b = b;
        if (s4) b4.cmd_valid = 1'b1;
        else    b1.cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            b1.cmd_valid = 1'b0;
            b4.cmd_valid = 1'b0;
            if (!(s4 ? b4.rsp_valid : b1.rsp_valid)) begin
                chk({tag, "/ctrl"}, 32'(s4 ? b4.alu_ctrl : b1.alu_ctrl), 32'(exp_ctrl));
                chk({tag, "/busy"}, 32'(s4 ? b4.cmd_ready : b1.cmd_ready), 32'd0);
            end
        end while (!(s4 ? b4.rsp_valid : b1.rsp_valid) && n < 30);
        chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "/data"}, 32'(s4 ? b4.rsp_data : b1.rsp_data), 32'(exp_dat));
        chk({tag, "/err"}, 32'(s4 ? b4.rsp_err : b1.rsp_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "/valid_drop"}, 32'(s4 ? b4.rsp_valid : b1.rsp_valid), 32'd0);
        chk({tag, "/done_cnt"}, 32'(s4 ? 16'(b4.done_cnt) : b1.done_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b1.cmd_valid = 1'b0; b1.cmd_op = OP_ADD; b1.cmd_a = '0; b1.cmd_b = '0; b1.rsp_ready = 1'b0;
        b4.cmd_valid = 1'b0; b4.cmd_op = OP_ADD; b4.cmd_a = '0; b4.cmd_b = '0; b4.rsp_ready = 1'b0;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/cmd_ready", 32'(b1.cmd_ready), 32'd0);
        chk("rst/alu_a", 32'(b1.alu_a), 32'd0);
        chk("rst/alu_b", 32'(b1.alu_b), 32'd0);
        chk("rst/alu_ctrl", 32'(b1.alu_ctrl), 32'h2);
        chk("rst/rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("rst/rsp_data", 32'(b1.rsp_data), 32'd0);
        chk("rst/rsp_err", 32'(b1.rsp_err), 32'd0);
        chk("rst/done_cnt", 32'(b1.done_cnt), 32'd0);
        rstn = 1'b1;
        b1.rsp_ready = 1'b1;
        b4.rsp_ready = 1'b1;
        @(negedge clk);

        // ADD, ALU_LAT=1
        run_op(1'b0, OP_ADD, 16'h0003, 16'h0005, CTRL_ADD, 16'h0008, 1'b0, 3, 1, "add");

        // SUB then MUL with cmd_valid held high across both
        b1.cmd_op = OP_SUB; b1.cmd_a = 16'h0010; b1.cmd_b = 16'h0001; b1.cmd_valid = 1'b1;
        @(negedge clk);
        b1.cmd_op = OP_MUL; b1.cmd_a = 16'h0004; b1.cmd_b = 16'h0006;
        n = 0;
        while (!b1.rsp_valid && n < 30) begin
            chk("b2b/ready_low", 32'(b1.cmd_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("b2b/sub_latency", 32'(n), 32'd2);
        chk("b2b/sub_data", 32'(b1.rsp_data), 32'h000F);
        @(negedge clk);
        chk("b2b/ready_gap", 32'(b1.cmd_ready), 32'd1);
        chk("b2b/cnt_after_sub", 32'(b1.done_cnt), 32'd2);
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        chk("b2b/mul_ctrl", 32'(b1.alu_ctrl), 32'(CTRL_MUL));
        chk("b2b/mul_alu_a", 32'(b1.alu_a), 32'h0004);
        n = 0;
        while (!b1.rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b/mul_data", 32'(b1.rsp_data), 32'h0018);
        @(negedge clk);
        chk("b2b/cnt_after_mul", 32'(b1.done_cnt), 32'd3);

        // Backpressure: response held for 10 cycles
        b1.rsp_ready = 1'b0;
        b1.cmd_op = OP_ADD; b1.cmd_a = 16'h1234; b1.cmd_b = 16'h0101; b1.cmd_valid = 1'b1;
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        n = 0;
        while (!b1.rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("bp/latency", 32'(n), 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk("bp/valid_held", 32'(b1.rsp_valid), 32'd1);
            chk("bp/data_held", 32'(b1.rsp_data), 32'h1335);
            chk("bp/err_held", 32'(b1.rsp_err), 32'd0);
            chk("bp/ready_low", 32'(b1.cmd_ready), 32'd0);
            chk("bp/cnt_held", 32'(b1.done_cnt), 32'd3);
            @(negedge clk);
        end
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp/valid_drop", 32'(b1.rsp_valid), 32'd0);
        chk("bp/cnt_once", 32'(b1.done_cnt), 32'd4);
        @(negedge clk);
        chk("bp/cnt_stable", 32'(b1.done_cnt), 32'd4);

        // Illegal opcode runs as ADD and is flagged
        run_op(1'b0, 2'b01, 16'h0001, 16'h0002, CTRL_ADD, 16'h0003, 1'b1, 3, 5, "illegal");
        // Following legal op clears the flag; ALU wraps the subtraction
        run_op(1'b0, OP_SUB, 16'h0005, 16'h0007, CTRL_SUB, 16'hFFFE, 1'b0, 3, 6, "sub_wrap");

        // ALU_LAT=4 instance: latency 6, 2-bit counter wraps 3 -> 0
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, t_op[i], t_a[i], t_b[i], t_ctrl[i], t_exp[i], 1'b0, 6, (i + 1) % 4, "lat4");
        end

        // Asynchronous reset while dut4 is in WAIT
        b4.cmd_op = OP_ADD; b4.cmd_a = 16'h0007; b4.cmd_b = 16'h0008; b4.cmd_valid = 1'b1;
        @(negedge clk);
        b4.cmd_valid = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst/ready4", 32'(b4.cmd_ready), 32'd0);
        chk("arst/alu_a4", 32'(b4.alu_a), 32'd0);
        chk("arst/alu_b4", 32'(b4.alu_b), 32'd0);
        chk("arst/valid4", 32'(b4.rsp_valid), 32'd0);
        chk("arst/cnt4", 32'(b4.done_cnt), 32'd0);
        chk("arst/ctrl1", 32'(b1.alu_ctrl), 32'h2);
        chk("arst/data1", 32'(b1.rsp_data), 32'd0);
        chk("arst/cnt1", 32'(b1.done_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("arst/ready4_post", 32'(b4.cmd_ready), 32'd1);
        chk("arst/ready1_post", 32'(b1.cmd_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("arst/no_rsp", 32'(b4.rsp_valid), 32'd0);
            chk("arst/cnt_zero", 32'(b4.done_cnt), 32'd0);
            @(negedge clk);
        end
        run_op(1'b1, OP_ADD, 16'h0007, 16'h0008, CTRL_ADD, 16'h000F, 1'b0, 6, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
